// File: rtl/fifo.sv
// Eight-entry, 32-bit single-clock FIFO with per-request acknowledge/error pulses,
// full/empty flags and an occupancy count.
//
// state    | meaning (result of the previous edge)
// NO_OP    | no request
// WRITE    | write accepted
// WR_ERROR | write rejected, FIFO full
// READ     | read accepted, dout updated
// RD_ERROR | read rejected, FIFO empty
// WR_RD    | simultaneous write and read accepted
// WR_RDERR | both requested while empty: write accepted, read rejected
// RD_WRERR | both requested while full: read accepted, write rejected
module fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic [3:0]       data_count,
    output logic             full,
    output logic             empty,
    output logic             wr_ack,
    output logic             wr_err,
    output logic             rd_ack,
    output logic             rd_err
);

    typedef enum logic [2:0] {
        NO_OP    = 3'd0,
        WRITE    = 3'd1,
        WR_ERROR = 3'd2,
        READ     = 3'd3,
        RD_ERROR = 3'd4,
        WR_RD    = 3'd5,
        WR_RDERR = 3'd6,
        RD_WRERR = 3'd7
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             do_wr;
    logic             do_rd;
    logic [2:0]       wp;
    logic [2:0]       rp;
    logic [3:0]       cnt;
    logic [WIDTH-1:0] mem [DEPTH];

    assign full       = (cnt == 4'(DEPTH));
    assign empty      = (cnt == 4'd0);
    assign data_count = cnt;

    // Decisions use the registered count, i.e. occupancy before this edge.
    always_comb begin
        state_nxt = NO_OP;
        do_wr     = 1'b0;
        do_rd     = 1'b0;
        case ({wr_en, rd_en})
            2'b10: begin
                if (full) begin
                    state_nxt = WR_ERROR;
                end else begin
                    state_nxt = WRITE;
                    do_wr     = 1'b1;
                end
            end
            2'b01: begin
                if (empty) begin
                    state_nxt = RD_ERROR;
                end else begin
                    state_nxt = READ;
                    do_rd     = 1'b1;
                end
            end
            2'b11: begin
                if (empty) begin
                    state_nxt = WR_RDERR;
                    do_wr     = 1'b1;
                end else if (full) begin
                    state_nxt = RD_WRERR;
                    do_rd     = 1'b1;
                end else begin
                    state_nxt = WR_RD;
                    do_wr     = 1'b1;
                    do_rd     = 1'b1;
                end
            end
            default: begin
                state_nxt = NO_OP;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= NO_OP;
            wp    <= 3'd0;
            rp    <= 3'd0;
            cnt   <= 4'd0;
            dout  <= '0;
        end else begin
            state <= state_nxt;
            if (do_wr) begin
                wp <= wp + 3'd1;
            end
            if (do_rd) begin
                rp   <= rp + 3'd1;
                dout <= mem[rp];
            end
            case ({do_wr, do_rd})
                2'b10:   cnt <= cnt + 4'd1;
                2'b01:   cnt <= cnt - 4'd1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage is deliberately not reset; stale words are unreachable once rp/wp/cnt clear.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wp] <= din;
        end
    end

    always_comb begin
        wr_ack = 1'b0;
        wr_err = 1'b0;
        rd_ack = 1'b0;
        rd_err = 1'b0;
        case (state)
            WRITE:    wr_ack = 1'b1;
            WR_ERROR: wr_err = 1'b1;
            READ:     rd_ack = 1'b1;
            RD_ERROR: rd_err = 1'b1;
            WR_RD: begin
                wr_ack = 1'b1;
                rd_ack = 1'b1;
            end
            WR_RDERR: begin
                wr_ack = 1'b1;
                rd_err = 1'b1;
            end
            RD_WRERR: begin
                rd_ack = 1'b1;
                wr_err = 1'b1;
            end
            default: begin
                wr_ack = 1'b0;
            end
        endcase
    end

endmodule
